// File: rtl/pifo_req_ingress.sv
// Request ingress for the PIFO tree I/O port: in-order request queue, one issue per
// cycle, back-off retry on task fail, and drop reporting after exhausting retries.
module pifo_req_ingress #(
    parameter int unsigned PTW           = 16,
    parameter int unsigned MTW           = 44,
    parameter int unsigned TREE_NUM      = 16,
    parameter int unsigned REQ_DEPTH     = 8,
    parameter int unsigned BACKOFF_CYC   = 2,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNTW          = 16,
    localparam int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int unsigned DW            = MTW + PTW
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_op,
    input  logic [TREE_NUM_BITS-1:0] i_req_tree_id,
    input  logic [DW-1:0]            i_req_data,
    output logic [TREE_NUM_BITS-1:0] o_tree_id,
    output logic                     o_push,
    output logic                     o_pop,
    output logic [DW-1:0]            o_push_data,
    input  logic                     i_task_fail,
    output logic                     o_drop,
    output logic [TREE_NUM_BITS-1:0] o_drop_tree_id,
    output logic [CNTW-1:0]          o_drop_cnt,
    output logic                     o_busy
);

    localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
    localparam int unsigned PW     = REQ_AW + 1;
    localparam int unsigned BOW    = (BACKOFF_CYC < 2) ? 1 : $clog2(BACKOFF_CYC);
    localparam int unsigned RTW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef struct packed {
        logic                     op;
        logic [TREE_NUM_BITS-1:0] tree_id;
        logic [DW-1:0]            data;
    } req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t          state, state_n;
    req_t            mem [REQ_DEPTH];
    req_t            head;
    logic [PW-1:0]   wr_ptr, rd_ptr, count, count_n;
    logic            empty, enq, deq, drop_set, remain;
    logic [RTW-1:0]  retry_cnt, retry_n;
    logic [BOW-1:0]  bo_cnt, bo_n;
    logic            is_issue;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (count == '0);
    assign enq    = i_req_valid && o_req_ready;
    assign head   = mem[rd_ptr[REQ_AW-1:0]];
    // Entries left once the head leaves, counting a same-cycle enqueue
    assign remain = (count > PW'(1)) || enq;
    assign count_n = count + PW'(enq) - PW'(deq);

    // Issue outputs come only from state and queue head registers
    assign is_issue    = (state == ISSUE);
    assign o_push      = is_issue && !head.op;
    assign o_pop       = is_issue && head.op;
    assign o_tree_id   = is_issue ? head.tree_id : '0;
    assign o_push_data = (is_issue && !head.op) ? head.data : '0;
    assign o_busy      = !empty || (state != IDLE);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state <= IDLE;
        else           state <= state_n;
    end

    // Next state plus dequeue / retry / back-off control
    always_comb begin
        state_n  = state;
        deq      = 1'b0;
        drop_set = 1'b0;
        retry_n  = retry_cnt;
        bo_n     = bo_cnt;
        case (state)
            IDLE: begin
                if (!empty || enq) state_n = ISSUE;
            end
            ISSUE: begin
                if (!i_task_fail || (retry_cnt == RTW'(MAX_RETRY))) begin
                    deq      = 1'b1;
                    drop_set = i_task_fail;
                    retry_n  = '0;
                    state_n  = remain ? ISSUE : IDLE;
                end else begin
                    retry_n = retry_cnt + RTW'(1);
                    bo_n    = BOW'(BACKOFF_CYC - 1);
                    state_n = BACKOFF;
                end
            end
            BACKOFF: begin
                if (bo_cnt == '0) state_n = ISSUE;
                else              bo_n    = bo_cnt - BOW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            retry_cnt      <= '0;
            bo_cnt         <= '0;
            o_req_ready    <= 1'b0;
            o_drop         <= 1'b0;
            o_drop_tree_id <= '0;
            o_drop_cnt     <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            retry_cnt   <= retry_n;
            bo_cnt      <= bo_n;
            o_req_ready <= (count_n != PW'(REQ_DEPTH));
            o_drop      <= drop_set;
            if (drop_set) begin
                o_drop_tree_id <= head.tree_id;
                if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNTW'(1);
            end
        end
    end

    // Queue storage needs no reset: pointers define validity
    always_ff @(posedge i_clk) begin
        if (enq) mem[wr_ptr[REQ_AW-1:0]] <= '{op: i_req_op, tree_id: i_req_tree_id, data: i_req_data};
    end

endmodule
